if_load_ctrl: RTL and testbench

On-chip load controller downstream of the async-FIFO read interface. Arbitrates load requests from the five on-chip consumers (config, activation, activation flag, weight, weight flag). For each granted request it issues the interface config pulse and code, then drains the returned 32-bit words through a 4-entry skid buffer into the destination buffer write port with an auto-incrementing address. Runs entirely in the `clk_chip` domain.

---
 rtl/if_load_ctrl_if.sv | 38 +++
 rtl/if_load_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_if_load_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_load_ctrl_if.sv
// Bundle of request, interface-FIFO and destination-buffer signals around the load controller.
// The controller side uses the master modport; the environment uses the slave modport.
interface if_load_ctrl_if #(
    parameter int unsigned SPI_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    localparam int unsigned NUM_SRC = 5;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned CFG_W   = 4;

    logic [NUM_SRC-1:0]    load_req;
    logic [NUM_SRC-1:0]    load_done;
    logic                  load_busy;
    logic                  config_ready;
    logic                  config_paulse;
    logic [CFG_W-1:0]      config_data;
    logic                  rd_req;
    logic                  rd_valid;
    logic [SPI_WIDTH-1:0]  rd_data;
    logic                  dst_ready;
    logic                  dst_wr;
    logic [CODE_W-1:0]     dst_sel;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [SPI_WIDTH-1:0]  dst_data;
    logic                  err_overrun;

    modport master (
        input  load_req, config_ready, rd_valid, rd_data, dst_ready,
        output load_done, load_busy, config_paulse, config_data, rd_req,
               dst_wr, dst_sel, dst_addr, dst_data, err_overrun
    );

    modport slave (
        output load_req, config_ready, rd_valid, rd_data, dst_ready,
        input  load_done, load_busy, config_paulse, config_data, rd_req,
               dst_wr, dst_sel, dst_addr, dst_data, err_overrun
    );
endinterface

// File: rtl/if_load_ctrl.sv
// Load controller: arbitrates consumer load requests, issues the interface config pulse,
// and drains returned words through a 4-entry skid buffer into the destination write port.
module if_load_ctrl #(
    parameter int unsigned SPI_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned RX_WIDTH       = 20,
    parameter int unsigned RD_SIZE_CFG    = 4,
    parameter int unsigned RD_SIZE_ACT    = 256,
    parameter int unsigned RD_SIZE_FLGACT = 32,
    parameter int unsigned RD_SIZE_WEI    = 512,
    parameter int unsigned RD_SIZE_FLGWEI = 64
) (
    input  logic           clk_chip,
    input  logic           reset_chip,
    if_load_ctrl_if.master bus
);
    localparam int unsigned NUM_SRC    = 5;
    localparam int unsigned CODE_W     = 3;
    localparam int unsigned CFG_W      = 4;
    localparam int unsigned SKID_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned LVL_W      = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RECV,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CODE_W-1:0]     cur_code_q, cur_code_d;
    logic [RX_WIDTH-1:0]   cur_size_q, cur_size_d;
    logic [RX_WIDTH-1:0]   recv_cnt_q, recv_cnt_d;
    logic [NUM_SRC-1:0]    load_done_q, load_done_d;
    logic                  load_busy_q, load_busy_d;
    logic                  config_paulse_q, config_paulse_d;
    logic [CFG_W-1:0]      config_data_q, config_data_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic                  err_overrun_q, err_overrun_d;
    logic [SPI_WIDTH-1:0]  skid_mem_q [SKID_DEPTH];
    logic [SPI_WIDTH-1:0]  skid_mem_d [SKID_DEPTH];
    logic [PTR_W-1:0]      skid_wptr_q, skid_wptr_d;
    logic [PTR_W-1:0]      skid_rptr_q, skid_rptr_d;
    logic [CNT_W-1:0]      skid_cnt_q, skid_cnt_d;

    logic                  grant_found;
    logic [CODE_W-1:0]     grant_code;
    logic [RX_WIDTH-1:0]   grant_size;
    logic                  push;
    logic                  pop;
    logic                  skid_full;
    logic [LVL_W-1:0]      req_level;

    // Lowest set request bit wins; its transfer size comes from the matching parameter.
    always_comb begin
        grant_found = 1'b0;
        grant_code  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_found && bus.load_req[i]) begin
                grant_code  = CODE_W'(i);
                grant_found = 1'b1;
            end
        end
        case (grant_code)
            3'd0:    grant_size = RX_WIDTH'(RD_SIZE_CFG);
            3'd1:    grant_size = RX_WIDTH'(RD_SIZE_ACT);
            3'd2:    grant_size = RX_WIDTH'(RD_SIZE_FLGACT);
            3'd3:    grant_size = RX_WIDTH'(RD_SIZE_WEI);
            default: grant_size = RX_WIDTH'(RD_SIZE_FLGWEI);
        endcase
    end

    // Next-state, counters, skid bookkeeping and registered-output decode.
    always_comb begin
        state_d         = state_q;
        cur_code_d      = cur_code_q;
        cur_size_d      = cur_size_q;
        recv_cnt_d      = recv_cnt_q;
        dst_addr_d      = dst_addr_q;
        config_paulse_d = 1'b0;
        skid_mem_d      = skid_mem_q;

        skid_full = (skid_cnt_q == CNT_W'(SKID_DEPTH));
        pop       = (skid_cnt_q != '0) && bus.dst_ready;
        // Words are only taken while a load still expects them and there is room.
        push      = bus.rd_valid && (state_q == S_RECV) && (recv_cnt_q < cur_size_q) && !skid_full;

        err_overrun_d = err_overrun_q | (bus.rd_valid & ~push);

        if (push) begin
            skid_mem_d[skid_wptr_q] = bus.rd_data;
        end
        skid_wptr_d = skid_wptr_q + PTR_W'(push);
        skid_rptr_d = skid_rptr_q + PTR_W'(pop);
        skid_cnt_d  = skid_cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (pop) begin
            dst_addr_d = dst_addr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    cur_code_d = grant_code;
                    cur_size_d = grant_size;
                    recv_cnt_d = '0;
                    dst_addr_d = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.config_ready) begin
                    config_paulse_d = 1'b1;
                    state_d         = S_RECV;
                end
            end
            S_RECV: begin
                if (push) begin
                    recv_cnt_d = recv_cnt_q + RX_WIDTH'(1);
                end
                if (recv_cnt_d >= cur_size_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Skid empty at cycle start means the last write has already gone out.
                if (skid_cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        load_done_d   = (state_d == S_DONE) ? (NUM_SRC'(1) << cur_code_d) : '0;
        load_busy_d   = (state_d != S_IDLE);
        config_data_d = (state_d != S_IDLE) ? CFG_W'(cur_code_d) : '0;
        // Leave room for the word already in the skid, the one in flight, and one more request.
        req_level     = LVL_W'(skid_cnt_d) + LVL_W'(rd_req_q);
        rd_req_d      = (state_d == S_RECV) && (req_level <= LVL_W'(2));
    end

    always_ff @(posedge clk_chip or posedge reset_chip) begin
        if (reset_chip) begin
            state_q         <= S_IDLE;
            cur_code_q      <= '0;
            cur_size_q      <= '0;
            recv_cnt_q      <= '0;
            load_done_q     <= '0;
            load_busy_q     <= 1'b0;
            config_paulse_q <= 1'b0;
            config_data_q   <= '0;
            rd_req_q        <= 1'b0;
            dst_addr_q      <= '0;
            err_overrun_q   <= 1'b0;
            skid_wptr_q     <= '0;
            skid_rptr_q     <= '0;
            skid_cnt_q      <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            cur_code_q      <= cur_code_d;
            cur_size_q      <= cur_size_d;
            recv_cnt_q      <= recv_cnt_d;
            load_done_q     <= load_done_d;
            load_busy_q     <= load_busy_d;
            config_paulse_q <= config_paulse_d;
            config_data_q   <= config_data_d;
            rd_req_q        <= rd_req_d;
            dst_addr_q      <= dst_addr_d;
            err_overrun_q   <= err_overrun_d;
            skid_wptr_q     <= skid_wptr_d;
            skid_rptr_q     <= skid_rptr_d;
            skid_cnt_q      <= skid_cnt_d;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem_q[i] <= skid_mem_d[i];
            end
        end
    end

    assign bus.load_done     = load_done_q;
    assign bus.load_busy     = load_busy_q;
    assign bus.config_paulse = config_paulse_q;
    assign bus.config_data   = config_data_q;
    assign bus.rd_req        = rd_req_q;
    assign bus.dst_sel       = cur_code_q;
    assign bus.dst_addr      = dst_addr_q;
    assign bus.err_overrun   = err_overrun_q;
    // The write port is decoded straight from the skid head so a ready cycle is never wasted.
    assign bus.dst_wr        = pop;
    assign bus.dst_data      = pop ? skid_mem_q[skid_rptr_q] : '0;

endmodule

// File: tb/tb_if_load_ctrl.sv
// Self-checking bench for if_load_ctrl: vector table of single loads, an interface-FIFO model
// feeding a write scoreboard, and hand sequences for arbitration, overrun and reset.
module tb_if_load_ctrl;
    logic clk_chip = 1'b0;
    logic reset_chip;

    if_load_ctrl_if #(.SPI_WIDTH(32), .ADDR_WIDTH(10)) bus ();

    if_load_ctrl dut (
        .clk_chip   (clk_chip),
        .reset_chip (reset_chip),
        .bus        (bus)
    );

    always #5 clk_chip = ~clk_chip;

    typedef struct packed {
        logic [2:0]  sel;
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  req;
        int          cfg_delay;
        bit          bp;
        logic [31:0] base;
        logic [4:0]  exp_done;
        int          exp_code;
        int          exp_lat;
        int          exp_words;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t sb[$];
    int   code_q[$];
    int   paulse_cnt = 0, paulse_cyc = 0, paulse_code = 0;
    int   wr_cnt = 0, first_wr_cyc = -1, last_wr_cyc = 0, done_cyc = 0;

    bit          bp_mode = 1'b0;
    bit          inject = 1'b0;
    bit          drain_inject = 1'b0;
    bit          rd_req_prev = 1'b0;
    int          words_left = 0, word_idx = 0, exp_addr = 0;
    logic [2:0]  mcode = '0;
    logic [31:0] data_base = '0;
    logic [31:0] mdata;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] code);
        case (code)
            3'd0:    return 4;
            3'd1:    return 256;
            3'd2:    return 32;
            3'd3:    return 512;
            default: return 64;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_chip);
        #2;
    endtask

    // Interface-FIFO model: answers each rd_req cycle with one word on the next cycle.
    always @(posedge clk_chip) begin
        cyc++;
        #1;
        if (reset_chip) begin
            bus.rd_valid = 1'b0;
            bus.rd_data  = '0;
            words_left   = 0;
            rd_req_prev  = 1'b0;
            inject       = 1'b0;
            sb.delete();
        end else begin
            bus.rd_valid = 1'b0;
            bus.rd_data  = '0;
            if (bus.config_paulse) begin
                mcode      = bus.config_data[2:0];
                words_left = size_of(mcode);
                word_idx   = 0;
                exp_addr   = 0;
            end
            if (inject) begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = 32'hDEAD_BEEF;
                inject       = 1'b0;
            end else if (rd_req_prev && words_left > 0) begin
                mdata        = data_base + 32'(word_idx);
                bus.rd_valid = 1'b1;
                bus.rd_data  = mdata;
                sb.push_back('{sel: mcode, addr: 10'(exp_addr), data: mdata});
                words_left--;
                word_idx++;
                exp_addr++;
                if (words_left == 0 && drain_inject) begin
                    inject       = 1'b1;
                    drain_inject = 1'b0;
                end
            end
            rd_req_prev = bus.rd_req;
        end
        bus.dst_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end

    // Output monitor: compares every destination write against the scoreboard head.
    always @(negedge clk_chip) begin
        exp_t e;
        if (!reset_chip) begin
            if (bus.config_paulse) begin
                paulse_cnt++;
                paulse_cyc  = cyc;
                paulse_code = int'(bus.config_data);
                code_q.push_back(int'(bus.config_data));
            end
            if (bus.load_done != '0) done_cyc = cyc;
            if (bus.dst_wr) begin
                wr_cnt++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr actual=%0h required=no write", bus.dst_data);
                end else begin
                    e = sb.pop_front();
                    check("dst_word", 64'({bus.dst_sel, bus.dst_addr, bus.dst_data}), 64'(e));
                end
            end
        end
    end

    task automatic wait_done(input logic [4:0] exp, input logic [4:0] next_req, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 3000) begin
            step();
            n++;
            if (bus.load_done != '0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no load_done required=%0h", name, exp);
        end else begin
            check({name, "_done"}, 64'(bus.load_done), 64'(exp));
        end
        bus.load_req = next_req;
    endtask

    task automatic run_vec(input vec_t v, input string name, input bit exp_err);
        int p0, w0, req_cyc;
        p0 = paulse_cnt;
        w0 = wr_cnt;
        first_wr_cyc = -1;
        data_base = v.base;
        bp_mode = v.bp;
        bus.load_req = v.req;
        bus.config_ready = (v.cfg_delay == 0);
        req_cyc = cyc;
        for (int i = 0; i < v.cfg_delay; i++) step();
        bus.config_ready = 1'b1;
        wait_done(v.exp_done, 5'b0, name);
        step();
        check({name, "_done_width"}, 64'(bus.load_done), 64'(0));
        check({name, "_paulse_cnt"}, 64'(paulse_cnt - p0), 64'(1));
        check({name, "_code"}, 64'(paulse_code), 64'(v.exp_code));
        check({name, "_latency"}, 64'(paulse_cyc - req_cyc), 64'(v.exp_lat));
        check({name, "_words"}, 64'(wr_cnt - w0), 64'(v.exp_words));
        check({name, "_wr_to_done"}, 64'(done_cyc - last_wr_cyc), 64'(2));
        if (!v.bp) begin
            check({name, "_first_wr"}, 64'(first_wr_cyc - paulse_cyc), 64'(2));
            check({name, "_span"}, 64'(last_wr_cyc - first_wr_cyc), 64'(v.exp_words - 1));
        end
        check({name, "_err"}, 64'(bus.err_overrun), 64'(exp_err));
        check({name, "_sb_empty"}, 64'(sb.size()), 64'(0));
        bp_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, n;

        vecs[0] = '{req: 5'b00001, cfg_delay: 0,  bp: 1'b0, base: 32'hA0,   exp_done: 5'b00001,
                    exp_code: 0, exp_lat: 2,  exp_words: 4};
        vecs[1] = '{req: 5'b00100, cfg_delay: 0,  bp: 1'b1, base: 32'h1000, exp_done: 5'b00100,
                    exp_code: 2, exp_lat: 2,  exp_words: 32};
        vecs[2] = '{req: 5'b10000, cfg_delay: 11, bp: 1'b0, base: 32'h2000, exp_done: 5'b10000,
                    exp_code: 4, exp_lat: 12, exp_words: 64};
        vecs[3] = '{req: 5'b01100, cfg_delay: 0,  bp: 1'b0, base: 32'h3000, exp_done: 5'b00100,
                    exp_code: 2, exp_lat: 2,  exp_words: 32};

        reset_chip       = 1'b1;
        bus.load_req     = '0;
        bus.config_ready = 1'b0;
        bus.rd_valid     = 1'b0;
        bus.rd_data      = '0;
        bus.dst_ready    = 1'b1;
        repeat (3) step();
        check("reset_outputs", 64'({bus.load_done, bus.load_busy, bus.config_paulse, bus.config_data,
              bus.rd_req, bus.dst_wr, bus.dst_sel, bus.dst_addr, bus.err_overrun, bus.dst_data}), 64'(0));
        reset_chip = 1'b0;
        step();
        check("idle_busy", 64'(bus.load_busy), 64'(0));

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Extra word arriving while the controller drains: dropped and flagged.
        drain_inject = 1'b1;
        run_vec(vecs[0], "drain_ovr", 1'b1);

        reset_chip = 1'b1;
        step();
        check("err_cleared", 64'(bus.err_overrun), 64'(0));
        reset_chip = 1'b0;
        step();

        // Stray word while idle.
        w0 = wr_cnt;
        inject = 1'b1;
        repeat (3) step();
        check("idle_ovr_err", 64'(bus.err_overrun), 64'(1));
        check("idle_ovr_nowr", 64'(wr_cnt - w0), 64'(0));
        check("idle_ovr_busy", 64'(bus.load_busy), 64'(0));
        repeat (5) step();
        check("err_sticky", 64'(bus.err_overrun), 64'(1));

        // Arbitration: ACT, then WEI, then FLGWEI as each requester drops its bit.
        code_q.delete();
        w0 = wr_cnt;
        data_base = 32'h4000;
        bus.config_ready = 1'b1;
        bus.load_req = 5'b11010;
        wait_done(5'b00010, 5'b11000, "arb_act");
        wait_done(5'b01000, 5'b10000, "arb_wei");
        wait_done(5'b10000, 5'b00000, "arb_flgwei");
        step();
        check("arb_grants", 64'(code_q.size()), 64'(3));
        if (code_q.size() == 3) begin
            check("arb_code0", 64'(code_q[0]), 64'(1));
            check("arb_code1", 64'(code_q[1]), 64'(3));
            check("arb_code2", 64'(code_q[2]), 64'(4));
        end
        check("arb_words", 64'(wr_cnt - w0), 64'(256 + 512 + 64));
        check("arb_err_sticky", 64'(bus.err_overrun), 64'(1));

        // Reset after 100 WEI words: outputs clear asynchronously.
        w0 = wr_cnt;
        n = 0;
        data_base = 32'h5000;
        bus.load_req = 5'b01000;
        while ((wr_cnt - w0) < 100 && n < 2000) begin
            step();
            n++;
        end
        check("mid_reached", 64'((wr_cnt - w0) >= 100), 64'(1));
        #1;
        reset_chip = 1'b1;
        bus.load_req = '0;
        #1;
        check("mid_reset_outputs", 64'({bus.load_done, bus.load_busy, bus.config_paulse, bus.config_data,
              bus.rd_req, bus.dst_wr, bus.dst_sel, bus.dst_addr, bus.err_overrun, bus.dst_data}), 64'(0));
        repeat (3) step();
        reset_chip = 1'b0;
        step();
        run_vec(vecs[0], "post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
